lab7_accumulator: RTL and testbench

Button-stepped 4-bit two's-complement accumulator that feeds the seven-segment display stage (`bi_digit`, `overflow`). It takes a raw pushbutton and switch inputs, synchronizes and debounces the button, and performs one load/add/subtract/clear operation per press. It holds the result and a sticky overflow flag for the display decoder downstream.

---
 rtl/lab7_accumulator.sv | 189 ++++++++++++++++++
 tb/tb_lab7_accumulator.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lab7_accumulator.sv
// Button-stepped 4-bit signed accumulator with key sync/debounce FSM.
// Optional ACC_SATURATE_EN: clamp to +7/-8 on add/sub overflow.
module lab7_accumulator #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key,
  input  logic [1:0] op,
  input  logic [3:0] operand,
  output logic [3:0] bi_digit,
  output logic       overflow,
  output logic       busy
);

  localparam int CW = 16;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    EXEC,
    WAIT_REL,
    DEB_REL
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_n;
  logic [CW-1:0]   count_inc;
  logic            sync1;
  logic            key_s;
  logic [3:0]      acc;
  logic [3:0]      acc_n;
  logic            ovf;
  logic            ovf_n;
  logic [3:0]      sum;
  logic [3:0]      diff;
  logic            add_ovf;
  logic            sub_ovf;
  logic            is_load;
  logic            is_add;
  logic            is_sub;
  logic            is_clr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      key_s <= 1'b0;
    end else begin
      sync1 <= key;
      key_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      count <= '0;
      acc   <= 4'b0000;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      acc   <= acc_n;
      ovf   <= ovf_n;
    end
  end

  assign count_inc = count + 1'b1;

  always_comb begin
    state_n = state;
    count_n = count;
    unique case (state)
      IDLE: begin
        if (key_s) begin
          state_n = DEB_PRESS;
          count_n = CW'(1);
        end
      end
      DEB_PRESS: begin
        if (!key_s) begin
          state_n = IDLE;
          count_n = '0;
        end else if (count_inc == DEB_LAST) begin
          state_n = EXEC;
          count_n = '0;
        end else begin
          count_n = count_inc;
        end
      end
      EXEC: begin
        state_n = WAIT_REL;
        count_n = '0;
      end
      WAIT_REL: begin
        if (!key_s) begin
          state_n = DEB_REL;
          count_n = CW'(1);
        end
      end
      DEB_REL: begin
        if (key_s) begin
          state_n = WAIT_REL;
          count_n = '0;
        end else if (count_inc == DEB_LAST) begin
          state_n = IDLE;
          count_n = '0;
        end else begin
          count_n = count_inc;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
  end

  assign sum     = acc + operand;
  assign diff    = acc - operand;
  assign add_ovf = (acc[3] == operand[3]) && (sum[3] != acc[3]);
  assign sub_ovf = (acc[3] != operand[3]) && (diff[3] != acc[3]);

  assign is_load = (op == 2'b00);
  assign is_add  = (op == 2'b01);
  assign is_sub  = (op == 2'b10);
  assign is_clr  = (op == 2'b11);

  // A wrapped result has the wrong sign, so its sign bit names the clamp side.
  always_comb begin
    acc_n = acc;
    ovf_n = ovf;
    if (state == EXEC) begin
      unique case (1'b1)
        is_load: begin
          acc_n = operand;
          ovf_n = 1'b0;
        end
        is_clr: begin
          acc_n = 4'b0000;
          ovf_n = 1'b0;
        end
        is_add: begin
          if (!ovf) begin
            if (add_ovf) begin
              ovf_n = 1'b1;
`ifdef ACC_SATURATE_EN
              acc_n = sum[3] ? 4'b0111 : 4'b1000;
`else
              acc_n = acc;
`endif
            end else begin
              acc_n = sum;
            end
          end
        end
        is_sub: begin
          if (!ovf) begin
            if (sub_ovf) begin
              ovf_n = 1'b1;
`ifdef ACC_SATURATE_EN
              acc_n = diff[3] ? 4'b0111 : 4'b1000;
`else
              acc_n = acc;
`endif
            end else begin
              acc_n = diff;
            end
          end
        end
        default: begin
          acc_n = acc;
          ovf_n = ovf;
        end
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  assign bi_digit = acc;
  assign overflow = ovf;

endmodule

// File: tb/tb_lab7_accumulator.sv
// Scoreboard bench for lab7_accumulator: expected acc/ovf queued per press,
// popped by a monitor whenever busy falls.
module tb_lab7_accumulator;

  logic       clk;
  logic       resetn;
  logic       key;
  logic [1:0] op;
  logic [3:0] operand;
  logic [3:0] bi_digit;
  logic       overflow;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [4:0] exp_q[$];
  logic       busy_q = 1'b0;

  lab7_accumulator #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .key      (key),
    .op       (op),
    .operand  (operand),
    .bi_digit (bi_digit),
    .overflow (overflow),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ACC_SATURATE_EN
  localparam logic [3:0] POS_OVF_ACC = 4'b0111;
`else
  localparam logic [3:0] POS_OVF_ACC = 4'b0101;
`endif

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Monitor: each completed key cycle (busy falling) retires one expectation.
  always @(negedge clk) begin
    if (busy_q && !busy) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        check("sb_acc", int'(bi_digit), int'(e[4:1]));
        check("sb_ovf", int'(overflow), int'(e[0]));
      end
    end
    busy_q <= busy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] o, input logic [3:0] v,
                       input logic [3:0] ea, input logic eo);
    exp_q.push_back({ea, eo});
    op      = o;
    operand = v;
    key     = 1'b1;
    tick(20);
    key = 1'b0;
    tick(10);
    check("idle_after_press", int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn  = 1'b0;
    key     = 1'b1;
    op      = 2'b00;
    operand = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_acc", int'(bi_digit), 0);
      check("rst_ovf", int'(overflow), 0);
      check("rst_busy", int'(busy), 0);
    end
    key = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(3);

    // Load 0101 with edge-exact latency checks.
    exp_q.push_back({4'b0101, 1'b0});
    op      = 2'b00;
    operand = 4'b0101;
    key     = 1'b1;
    tick(2);
    check("busy_pre", int'(busy), 0);
    tick(1);
    check("busy_rise", int'(busy), 1);
    tick(3);
    check("acc_before_exec", int'(bi_digit), 0);
    tick(1);
    check("acc_after_exec", int'(bi_digit), 5);
    tick(13);
    check("no_repeat", int'(bi_digit), 5);
    key = 1'b0;
    tick(5);
    check("busy_hold_rel", int'(busy), 1);
    tick(1);
    check("busy_fall", int'(busy), 0);
    tick(4);

    press(2'b01, 4'b0011, POS_OVF_ACC, 1'b1);
    press(2'b01, 4'b0001, POS_OVF_ACC, 1'b1);
    press(2'b11, 4'b0110, 4'b0000, 1'b0);
    press(2'b00, 4'b1000, 4'b1000, 1'b0);
    press(2'b10, 4'b0001, 4'b1000, 1'b1);
    press(2'b00, 4'b0011, 4'b0011, 1'b0);
    press(2'b01, 4'b1110, 4'b0001, 1'b0);
    press(2'b10, 4'b0100, 4'b1101, 1'b0);
    press(2'b10, 4'b1000, 4'b0101, 1'b0);
    press(2'b10, 4'b1001, POS_OVF_ACC, 1'b1);
    press(2'b00, 4'b0111, 4'b0111, 1'b0);
    press(2'b01, 4'b1000, 4'b1111, 1'b0);

    // Short glitches: busy pulses but nothing executes.
    op      = 2'b00;
    operand = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({4'b1111, 1'b0});
      key = 1'b1;
      tick(3);
      key = 1'b0;
      tick(8);
    end
    check("glitch_acc", int'(bi_digit), 15);
    check("glitch_busy", int'(busy), 0);

    // Reset while DEB_PRESS count is 3 with a load pending.
    exp_q.push_back({4'b0000, 1'b0});
    op      = 2'b00;
    operand = 4'b0011;
    key     = 1'b1;
    tick(5);
    check("pre_rst_busy", int'(busy), 1);
    resetn = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_acc", int'(bi_digit), 0);
    key = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(10);
    check("postrst_acc", int'(bi_digit), 0);
    check("postrst_ovf", int'(overflow), 0);
    check("postrst_busy", int'(busy), 0);

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
